// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester bundle plus register-file write port
//   req/req_addr/req_data : requester -> arbiter (NREQ requests, 5-bit addr, 32-bit data each)
//   gnt                   : arbiter -> requesters, one-hot grant
//   we3/a3/wd3            : arbiter -> register file write port
//   init_busy/dropped     : arbiter status
interface regfile_write_arbiter_if #(parameter int NREQ = 3);
  logic [NREQ-1:0] req;
  logic [5*NREQ-1:0] req_addr;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0] gnt;
  logic we3;
  logic [4:0] a3;
  logic [31:0] wd3;
  logic init_busy;
  logic dropped;
  modport master(output req, req_addr, req_data, input gnt, we3, a3, wd3, init_busy, dropped);
  modport slave(input req, req_addr, req_data, output gnt, we3, a3, wd3, init_busy, dropped);
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: init sweep of all 32 registers, then round-robin sharing of the write port
//   clk, rst : clock and asynchronous active-high reset
//   bus_if   : slave side of regfile_write_arbiter_if (requests in, grant and write port out)
module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int INIT_EN = 1,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000,
  parameter int ZERO_PROTECT = 1
) (
  input logic clk,
  input logic rst,
  regfile_write_arbiter_if.slave bus_if
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic {INIT, ARB} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic we_q, we_d;
  logic [4:0] a_q, a_d;
  logic [31:0] wd_q, wd_d;
  logic drop_q, drop_d;
  logic found, grant, zero;
  logic [PW-1:0] gi;
  logic [4:0] addr;
  int j;
  // first requester at or after ptr, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    gi = '0;
    j = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_q) + k) % NREQ;
      if (!found && bus_if.req[j]) begin
        found = 1'b1;
        gi = PW'(j);
      end
    end
    grant = found && state_q == ARB && !rst;
    bus_if.gnt = grant ? NREQ'(1) << gi : '0;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    we_d = 1'b0;
    a_d = a_q;
    wd_d = wd_q;
    drop_d = 1'b0;
    addr = bus_if.req_addr[int'(gi)*5 +: 5];
    zero = ZERO_PROTECT != 0 && addr == 5'd0;
    if (state_q == INIT) begin
      we_d = 1'b1;
      a_d = cnt_q;
      wd_d = INIT_VALUE;
      cnt_d = cnt_q + 5'd1;
      state_d = cnt_q == 5'd31 ? ARB : INIT;
    end else if (grant) begin
      we_d = !zero;
      drop_d = zero;
      a_d = zero ? a_q : addr;
      wd_d = zero ? wd_q : bus_if.req_data[int'(gi)*32 +: 32];
      ptr_d = gi == PW'(NREQ - 1) ? '0 : gi + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT_EN != 0 ? INIT : ARB;
      cnt_q <= '0;
      ptr_q <= '0;
      we_q <= 1'b0;
      a_q <= '0;
      wd_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      we_q <= we_d;
      a_q <= a_d;
      wd_q <= wd_d;
      drop_q <= drop_d;
    end
  end
  assign bus_if.we3 = we_q;
  assign bus_if.a3 = a_q;
  assign bus_if.wd3 = wd_q;
  assign bus_if.dropped = drop_q;
  assign bus_if.init_busy = state_q == INIT;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench with a queue-based reference model of the arbiter
module tb_regfile_write_arbiter;
  localparam int N = 3;
  localparam logic [31:0] IV = 32'h0000_0000;
  typedef struct {logic we; logic [4:0] a; logic [31:0] wd; logic drop;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t me;
  logic [N-1:0] pend = '0;
  logic [4:0] paddr[N];
  logic [31:0] pdata[N];
  int mptr = 0;
  int init_left = 32;
  regfile_write_arbiter_if #(.NREQ(N)) b0();
  regfile_write_arbiter_if #(.NREQ(N)) b1();
  regfile_write_arbiter #(.NREQ(N), .INIT_EN(1), .INIT_VALUE(IV), .ZERO_PROTECT(1)) u0 (.clk(clk), .rst(rst), .bus_if(b0));
  regfile_write_arbiter #(.NREQ(N), .INIT_EN(0), .INIT_VALUE(IV), .ZERO_PROTECT(1)) u1 (.clk(clk), .rst(rst), .bus_if(b1));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction
  task automatic model_reset();
    sb.delete();
    pend = '0;
    mptr = 0;
    init_left = 32;
  endtask
  // one cycle: refill idle requesters, drive, predict grant and the write it causes, advance to next negedge
  task automatic step(input logic [N-1:0] want, input logic [5*N-1:0] ad, input logic [32*N-1:0] dt);
    int w;
    exp_t e;
    logic [N-1:0] eg;
    for (int i = 0; i < N; i++)
      if (!pend[i] && want[i]) begin
        pend[i] = 1'b1;
        paddr[i] = ad[5*i +: 5];
        pdata[i] = dt[32*i +: 32];
      end
    b0.req = pend;
    for (int i = 0; i < N; i++) begin
      b0.req_addr[5*i +: 5] = paddr[i];
      b0.req_data[32*i +: 32] = pdata[i];
    end
    #1;
    check("init_busy", 32'(b0.init_busy), 32'(init_left > 0));
    eg = '0;
    if (init_left > 0) begin
      e = '{1'b1, 5'(32 - init_left), IV, 1'b0};
      sb.push_back(e);
      init_left--;
    end else begin
      w = pick(pend);
      if (w >= 0) begin
        eg[w] = 1'b1;
        e = paddr[w] == 5'd0 ? '{1'b0, 5'd0, 32'd0, 1'b1} : '{1'b1, paddr[w], pdata[w], 1'b0};
        sb.push_back(e);
        pend[w] = 1'b0;
        mptr = (w + 1) % N;
      end
    end
    check("gnt", 32'(b0.gnt), 32'(eg));
    @(negedge clk);
  endtask
  always @(posedge clk) begin
    #1;
    if (!rst && (b0.we3 || b0.dropped)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_write: we3=%b dropped=%b a3=%0d with no expected write", b0.we3, b0.dropped, b0.a3);
      end else begin
        me = sb.pop_front();
        check("we3", 32'(b0.we3), 32'(me.we));
        check("dropped", 32'(b0.dropped), 32'(me.drop));
        if (me.we) begin
          check("a3", 32'(b0.a3), 32'(me.a));
          check("wd3", b0.wd3, me.wd);
        end
      end
    end
  end
  initial begin
    b0.req = '0;
    b0.req_addr = '0;
    b0.req_data = '0;
    b1.req = '0;
    b1.req_addr = '0;
    b1.req_data = '0;
    for (int i = 0; i < N; i++) begin
      paddr[i] = '0;
      pdata[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_we3", 32'(b0.we3), 0);
    check("rst_a3", 32'(b0.a3), 0);
    check("rst_wd3", b0.wd3, 0);
    check("rst_dropped", 32'(b0.dropped), 0);
    check("rst_gnt", 32'(b0.gnt), 0);
    check("rst_init_busy", 32'(b0.init_busy), 1);
    check("u1_rst_init_busy", 32'(b1.init_busy), 0);
    rst = 1'b0;
    b1.req = 3'b010;
    b1.req_addr = {5'd0, 5'd4, 5'd0};
    b1.req_data = {32'd0, 32'hCAFE_0001, 32'd0};
    #1;
    check("u1_gnt", 32'(b1.gnt), 32'b010);
    // requester 0 waits through the whole sweep
    step(3'b001, {5'd0, 5'd0, 5'd9}, {32'd0, 32'd0, 32'h0000_1234});
    check("u1_we3", 32'(b1.we3), 1);
    check("u1_a3", 32'(b1.a3), 4);
    check("u1_wd3", b1.wd3, 32'hCAFE_0001);
    b1.req = '0;
    step('0, '0, '0);
    check("u1_idle_we3", 32'(b1.we3), 0);
    repeat (31) step('0, '0, '0);
    repeat (3) step('0, '0, '0);
    repeat (3) step(3'b100, {5'd17, 5'd0, 5'd0}, {32'hDEAD_BEEF, 32'd0, 32'd0});
    repeat (5) step(3'b111, {5'd7, 5'd6, 5'd5}, {32'h0000_7777, 32'h0000_6666, 32'h0000_5555});
    repeat (3) step('0, '0, '0);
    step(3'b010, {5'd0, 5'd0, 5'd0}, '0);
    step('0, '0, '0);
    step(3'b010, {5'd0, 5'd3, 5'd0}, {32'd0, 32'h0000_0033, 32'd0});
    repeat (2) step('0, '0, '0);
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) step(3'b011, {5'd0, 5'd1, 5'd2}, {32'd0, 32'h11, 32'h22});
    #2;
    rst = 1'b1;
    #1;
    check("midrst_we3", 32'(b0.we3), 0);
    check("midrst_a3", 32'(b0.a3), 0);
    check("midrst_wd3", b0.wd3, 0);
    check("midrst_gnt", 32'(b0.gnt), 0);
    check("midrst_init_busy", 32'(b0.init_busy), 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) step('0, '0, '0);
    for (int t = 0; t < 400; t++)
      step(N'($urandom), 5*N'({$urandom, $urandom}), {$urandom, $urandom, $urandom});
    repeat (5) step('0, '0, '0);
    check("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
